// File: rtl/iterative_right_shifter_pkg.sv
// Shared definitions for the iterative right shifter: FSM encoding, stage count,
// per-stage shift amounts and the next-set-stage search used by the skip build.
package iterative_right_shifter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int STAGES = 5;

    typedef logic [2:0] stage_idx_t;

    // Returned by next_set_stage when no further shamt bit is set.
    localparam stage_idx_t STAGE_NONE = 3'(STAGES);

    function automatic int stage_amount(input int k);
        return 16 >> k;
    endfunction

    // Lowest stage index >= from whose shamt bit (STAGES-1-k) is set.
    function automatic stage_idx_t next_set_stage(input logic [STAGES-1:0] shamt,
                                                  input stage_idx_t from);
        stage_idx_t r;
        r = STAGE_NONE;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (i >= int'(from) && shamt[STAGES-1-i]) begin
                r = stage_idx_t'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/iterative_right_shifter_stage.sv
// One fixed-amount right-shift stage: shifts by AMOUNT with zero or sign fill
// when enabled, otherwise passes data through unchanged.
module right_shift_stage #(
    parameter int WIDTH  = 32,
    parameter int AMOUNT = 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic             arith,
    input  logic             enable,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] fill_mask;
    logic [WIDTH-1:0] shifted;

    // Upper AMOUNT bits are replaced with the sign bit when arithmetic.
    assign fill_mask = ~({WIDTH{1'b1}} >> AMOUNT) & {WIDTH{arith & data[WIDTH-1]}};
    assign shifted   = (data >> AMOUNT) | fill_mask;
    assign result    = enable ? shifted : data;

endmodule

// File: rtl/iterative_right_shifter.sv
// Multi-cycle right shifter applying one binary stage (16,8,4,2,1) per clock.
// Define SKIP_ZERO_STAGES_EN to visit only the stages whose shamt bit is set.
module iterative_right_shifter
    import iterative_right_shifter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               ctrl_start,
    input  logic               ctrl_arith,
    input  logic [WIDTH-1:0]   data_operand,
    input  logic [SHAMT_W-1:0] data_shamt,
    output logic               data_busy,
    output logic               data_resultRDY,
    output logic [WIDTH-1:0]   data_result
);

    state_t             state_reg;
    stage_idx_t         k_reg;
    logic [WIDTH-1:0]   acc_reg;
    logic [SHAMT_W-1:0] shamt_reg;
    logic               arith_reg;
    logic               busy_reg;
    logic               rdy_reg;
    logic [WIDTH-1:0]   result_reg;

    logic [WIDTH-1:0]   stage_out [STAGES];
    logic [WIDTH-1:0]   stage_sel;
    stage_idx_t         k_first;
    stage_idx_t         k_next;
    logic               last_stage;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            right_shift_stage #(
                .WIDTH  (WIDTH),
                .AMOUNT (stage_amount(gi))
            ) u_stage (
                .data   (acc_reg),
                .arith  (arith_reg),
                .enable (shamt_reg[SHAMT_W-1-gi]),
                .result (stage_out[gi])
            );
        end
    endgenerate

    always_comb begin
        stage_sel = stage_out[k_reg];
`ifdef SKIP_ZERO_STAGES_EN
        // shamt=0 still spends one SHIFT cycle on stage 0, which is disabled.
        k_first = next_set_stage(data_shamt, '0);
        if (k_first == STAGE_NONE) begin
            k_first = '0;
        end
        k_next     = next_set_stage(shamt_reg, k_reg + 3'd1);
        last_stage = (k_next == STAGE_NONE);
`else
        k_first    = '0;
        k_next     = k_reg + 3'd1;
        last_stage = (k_reg == 3'(STAGES - 1));
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            k_reg      <= '0;
            acc_reg    <= '0;
            shamt_reg  <= '0;
            arith_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            rdy_reg    <= 1'b0;
            result_reg <= '0;
        end else begin
            rdy_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (ctrl_start) begin
                        acc_reg   <= data_operand;
                        shamt_reg <= data_shamt;
                        arith_reg <= ctrl_arith;
                        k_reg     <= k_first;
                        busy_reg  <= 1'b1;
                        state_reg <= SHIFT;
                    end else begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                SHIFT: begin
                    acc_reg <= stage_sel;
                    if (last_stage) begin
                        state_reg  <= DONE;
                        busy_reg   <= 1'b0;
                        rdy_reg    <= 1'b1;
                        result_reg <= stage_sel;
                    end else begin
                        k_reg <= k_next;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign data_busy      = busy_reg;
    assign data_resultRDY = rdy_reg;
    assign data_result    = result_reg;

endmodule

// File: tb/tb_iterative_right_shifter.sv
// Directed bench for iterative_right_shifter; latency counts include the start edge.
// Build with SKIP_ZERO_STAGES_EN to check the skip-stage latencies.
module tb_iterative_right_shifter;

    logic        clock;
    logic        reset_n;
    logic        ctrl_start;
    logic        ctrl_arith;
    logic [31:0] data_operand;
    logic [4:0]  data_shamt;
    logic        data_busy;
    logic        data_resultRDY;
    logic [31:0] data_result;

    int checks = 0;
    int errors = 0;

    iterative_right_shifter #(
        .WIDTH   (32),
        .SHAMT_W (5)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_start     (ctrl_start),
        .ctrl_arith     (ctrl_arith),
        .data_operand   (data_operand),
        .data_shamt     (data_shamt),
        .data_busy      (data_busy),
        .data_resultRDY (data_resultRDY),
        .data_result    (data_result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Called at a negedge; start is sampled at the next posedge (edge N).
    task automatic issue(input logic [31:0] op, input logic [4:0] sh, input logic ar);
        data_operand = op;
        data_shamt   = sh;
        ctrl_arith   = ar;
        ctrl_start   = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ctrl_start   = 1'b0;
    endtask

    // Samples once per negedge from just after edge N until the ready pulse.
    // Returns positioned at the negedge of the DONE cycle.
    task automatic await(input string tag, input logic [31:0] exp,
                         input int busy_full, input int busy_skip, input bit intrude);
        int  lat;
        int  busy_n;
        bit  seen;
        int  exp_busy;
`ifdef SKIP_ZERO_STAGES_EN
        exp_busy = busy_skip;
`else
        exp_busy = busy_full;
`endif
        lat    = 1;
        busy_n = 0;
        seen   = 1'b0;
        while (lat <= 20) begin
            if (data_resultRDY) begin
                seen = 1'b1;
                break;
            end
            if (data_busy) busy_n++;
            if (intrude && lat == 1) begin
                data_operand = 32'h0000FFFF;
                data_shamt   = 5'd0;
                ctrl_arith   = 1'b1;
                ctrl_start   = 1'b1;
            end else begin
                ctrl_start   = 1'b0;
            end
            @(negedge clock);
            lat++;
        end
        check({tag, "_pulse"}, 32'(seen), 32'd1);
        check({tag, "_result"}, data_result, exp);
        check({tag, "_busy"}, 32'(busy_n), 32'(exp_busy));
        check({tag, "_lat"}, 32'(lat), 32'(exp_busy + 1));
    endtask

    // Pulse lasts one cycle and the result holds afterwards.
    task automatic after_done(input string tag, input logic [31:0] exp);
        @(negedge clock);
        check({tag, "_rdy_drop"}, 32'(data_resultRDY), 32'd0);
        check({tag, "_hold"}, data_result, exp);
    endtask

    initial begin
        int pulses;
        reset_n      = 1'b0;
        ctrl_start   = 1'b0;
        ctrl_arith   = 1'b0;
        data_operand = 32'h0;
        data_shamt   = 5'd0;
        repeat (3) @(negedge clock);
        check("reset_busy", 32'(data_busy), 32'd0);
        check("reset_rdy", 32'(data_resultRDY), 32'd0);
        check("reset_result", data_result, 32'h0);
        reset_n = 1'b1;
        @(negedge clock);

        issue(32'h80000000, 5'd31, 1'b0);
        await("t1_srl31", 32'h00000001, 5, 5, 1'b0);
        after_done("t1", 32'h00000001);

        issue(32'h80000000, 5'd31, 1'b1);
        await("t2_sra31", 32'hFFFFFFFF, 5, 5, 1'b0);
        after_done("t2", 32'hFFFFFFFF);

        issue(32'h12345678, 5'd4, 1'b1);
        await("t3_sra4", 32'h01234567, 5, 1, 1'b0);
        after_done("t3", 32'h01234567);

        issue(32'hDEADBEEF, 5'd0, 1'b0);
        await("t4_sh0", 32'hDEADBEEF, 5, 1, 1'b0);
        issue(32'hDEADBEEF, 5'd8, 1'b0);
        await("t4_b2b_srl8", 32'h00DEADBE, 5, 1, 1'b0);
        after_done("t4", 32'h00DEADBE);

        issue(32'hDEADBEEF, 5'd8, 1'b1);
        await("t4x_sra8", 32'hFFDEADBE, 5, 1, 1'b0);
        after_done("t4x", 32'hFFDEADBE);

        issue(32'h80000000, 5'd1, 1'b1);
        await("tx_sra1", 32'hC0000000, 5, 1, 1'b0);
        after_done("tx", 32'hC0000000);

        issue(32'hF0F0F0F0, 5'd12, 1'b0);
        await("t5_midstart", 32'h000F0F0F, 5, 2, 1'b1);
        after_done("t5", 32'h000F0F0F);

        // Abort while stage k=2 is pending (third cycle after the start edge).
        issue(32'h12345678, 5'd31, 1'b1);
        @(negedge clock);
        @(negedge clock);
        check("t6_busy_before", 32'(data_busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("t6_busy_rst", 32'(data_busy), 32'd0);
        check("t6_rdy_rst", 32'(data_resultRDY), 32'd0);
        check("t6_result_rst", data_result, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        pulses = 0;
        repeat (10) begin
            @(negedge clock);
            if (data_resultRDY || data_busy) pulses++;
        end
        check("t6_no_pulse", 32'(pulses), 32'd0);

        issue(32'h87654321, 5'd16, 1'b1);
        await("t6_after", 32'hFFFF8765, 5, 1, 1'b0);
        after_done("t6", 32'hFFFF8765);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
